// File: rtl/cnn_avalon_stream_ctrl.sv
// Avalon-MM slave front end for the CNN classifier core.
// Buffers pixels in a FIFO, streams them to the core over valid/ready,
// and tracks frame progress, the latched decision and a done interrupt.
//
// state  | meaning
// S_IDLE | no frame in progress, FIFO may be prefilled
// S_RUN  | streaming pixels to the core, counting handshakes
// S_WAIT | all pixels delivered, waiting for the core finish flag
// S_DONE | decision latched, done set until acknowledged or restarted
module cnn_avalon_stream_ctrl #(
  parameter int PIX_W      = 8,
  parameter int CLASS_W    = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int NUM_PIXELS = 784,
  parameter int CNT_W      = 16
) (
  input  logic               iClk,
  input  logic               iReset_n,
  input  logic               iChipSelect_n,
  input  logic               iWrite_n,
  input  logic               iRead_n,
  input  logic [2:0]         iAddress,
  input  logic [31:0]        iData,
  output logic [31:0]        oData,
  output logic               oIrq,
  output logic [PIX_W-1:0]   oPixel,
  output logic               oPixelValid,
  input  logic               iPixelReady,
  input  logic [CLASS_W-1:0] iDecision,
  input  logic               iFinish,
  output logic               oCoreRst_n
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;

  state_t stateQ, stateNext;

  logic [PIX_W-1:0]   fifoMem [FIFO_DEPTH];
  logic [AW:0]        wrPtr, rdPtr;
  logic [LW-1:0]      level;
  logic               fifoEmpty, fifoFull;
  logic [CNT_W-1:0]   pixCnt;
  logic [CLASS_W-1:0] decisionQ;
  logic               doneQ, overflowQ, irqEn;
  logic [31:0]        rdMux;

  logic wr, rd, wrPix, wrCtrl, wrAck;
  logic startCmd, clearCmd, startAcc, finishEvt;
  logic pop, pushOk, lastPix, irqEnNext, busy;
  logic unusedData;

  assign wr       = !iChipSelect_n && !iWrite_n;
  assign rd       = !iChipSelect_n && !iRead_n;
  assign wrPix    = wr && (iAddress == 3'd0);
  assign wrCtrl   = wr && (iAddress == 3'd2);
  assign wrAck    = wr && (iAddress == 3'd4) && iData[0];
  // CLEAR takes priority, so a START carried in the same write is dropped
  assign clearCmd = wrCtrl && iData[1];
  assign startCmd = wrCtrl && iData[0] && !iData[1];
  assign unusedData = ^iData;

  assign level     = LW'(wrPtr - rdPtr);
  assign fifoEmpty = (level == '0);
  assign fifoFull  = (level == LW'(FIFO_DEPTH));

  assign oPixelValid = (stateQ == S_RUN) && !fifoEmpty;
  assign oPixel      = fifoEmpty ? '0 : fifoMem[rdPtr[AW-1:0]];
  assign pop         = oPixelValid && iPixelReady;
  assign pushOk      = wrPix && (!fifoFull || pop);
  assign lastPix     = (pixCnt == CNT_W'(NUM_PIXELS - 1));
  assign busy        = (stateQ == S_RUN) || (stateQ == S_WAIT);
  assign irqEnNext   = wrCtrl ? iData[2] : irqEn;

  // State register
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) stateQ <= S_IDLE;
    else           stateQ <= stateNext;
  end

  // Next-state logic and frame events
  always_comb begin
    stateNext = stateQ;
    startAcc  = 1'b0;
    finishEvt = 1'b0;
    case (stateQ)
      S_IDLE: if (startCmd) begin stateNext = S_RUN; startAcc = 1'b1; end
      S_RUN:  if (pop && lastPix) stateNext = S_WAIT;
      S_WAIT: if (iFinish) begin stateNext = S_DONE; finishEvt = !clearCmd; end
      S_DONE: if (startCmd) begin stateNext = S_RUN; startAcc = 1'b1; end
      default: stateNext = S_IDLE;
    endcase
    if (clearCmd) stateNext = S_IDLE;
  end

  // FIFO storage; contents are don't-care while empty so no reset needed
  always_ff @(posedge iClk) begin
    if (pushOk) fifoMem[wrPtr[AW-1:0]] <= iData[PIX_W-1:0];
  end

  // FIFO pointers, flushed by CLEAR
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else if (clearCmd) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (pop)    rdPtr <= rdPtr + 1'b1;
    end
  end

  // Frame status: pixel count, sticky overflow, done, decision, irq enable
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      pixCnt    <= '0;
      overflowQ <= 1'b0;
      doneQ     <= 1'b0;
      decisionQ <= '0;
      irqEn     <= 1'b0;
    end else begin
      if (clearCmd || startAcc) pixCnt <= '0;
      else if (pop)             pixCnt <= pixCnt + 1'b1;

      if (clearCmd)                overflowQ <= 1'b0;
      else if (wrPix && !pushOk)   overflowQ <= 1'b1;

      if (clearCmd)               doneQ <= 1'b0;
      else if (finishEvt)         doneQ <= 1'b1;
      else if (wrAck || startAcc) doneQ <= 1'b0;

      if (finishEvt) decisionQ <= iDecision;
      if (wrCtrl)    irqEn     <= iData[2];
    end
  end

  // Interrupt, core soft reset pulse and registered read data
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      oIrq       <= 1'b0;
      oCoreRst_n <= 1'b1;
      oData      <= '0;
    end else begin
      oIrq       <= doneQ && irqEnNext && !(wrAck || clearCmd || startAcc);
      oCoreRst_n <= !clearCmd;
      if (rd) oData <= rdMux;
    end
  end

  // Read data selection
  always_comb begin
    rdMux = '0;
    case (iAddress)
      3'd0: rdMux[CLASS_W-1:0] = decisionQ;
      3'd1: begin
        rdMux[0]       = busy;
        rdMux[1]       = doneQ;
        rdMux[2]       = overflowQ;
        rdMux[3]       = fifoEmpty;
        rdMux[4]       = fifoFull;
        rdMux[8 +: LW] = level;
      end
      3'd2: rdMux[2] = irqEn;
      3'd3: rdMux[CNT_W-1:0] = pixCnt;
      default: rdMux = '0;
    endcase
  end

endmodule

// File: tb/tb_cnn_avalon_stream_ctrl.sv
// Directed bench for the CNN Avalon stream controller (NUM_PIXELS = 4).
module tb_cnn_avalon_stream_ctrl;

  localparam int PIX_W = 8;
  localparam int CLASS_W = 4;

  logic               iClk = 1'b0;
  logic               iReset_n;
  logic               iChipSelect_n, iWrite_n, iRead_n;
  logic [2:0]         iAddress;
  logic [31:0]        iData;
  logic [31:0]        oData;
  logic               oIrq;
  logic [PIX_W-1:0]   oPixel;
  logic               oPixelValid;
  logic               iPixelReady;
  logic [CLASS_W-1:0] iDecision;
  logic               iFinish;
  logic               oCoreRst_n;

  int nChecks = 0;
  int nFails  = 0;

  cnn_avalon_stream_ctrl #(
    .PIX_W(8), .CLASS_W(4), .FIFO_DEPTH(16), .NUM_PIXELS(4), .CNT_W(16)
  ) dut (
    .iClk(iClk), .iReset_n(iReset_n), .iChipSelect_n(iChipSelect_n),
    .iWrite_n(iWrite_n), .iRead_n(iRead_n), .iAddress(iAddress),
    .iData(iData), .oData(oData), .oIrq(oIrq), .oPixel(oPixel),
    .oPixelValid(oPixelValid), .iPixelReady(iPixelReady),
    .iDecision(iDecision), .iFinish(iFinish), .oCoreRst_n(oCoreRst_n)
  );

  always #5 iClk = ~iClk;

  task automatic busWrite(input logic [2:0] a, input logic [31:0] d);
    @(negedge iClk);
    iChipSelect_n = 1'b0; iWrite_n = 1'b0; iAddress = a; iData = d;
    @(negedge iClk);
    iChipSelect_n = 1'b1; iWrite_n = 1'b1;
  endtask

  task automatic busRead(input logic [2:0] a, output logic [31:0] d);
    @(negedge iClk);
    iChipSelect_n = 1'b0; iRead_n = 1'b0; iAddress = a;
    @(negedge iClk);
    iChipSelect_n = 1'b1; iRead_n = 1'b1;
    d = oData;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    iReset_n = 1'b0;
    repeat (2) @(negedge iClk);
    nChecks++; if (oData !== 32'h0) begin nFails++; $display("FAIL reset_odata: got %h want 0", oData); end
    nChecks++; if (oPixelValid !== 1'b0) begin nFails++; $display("FAIL reset_valid: got %b want 0", oPixelValid); end
    nChecks++; if (oIrq !== 1'b0) begin nFails++; $display("FAIL reset_irq: got %b want 0", oIrq); end
    nChecks++; if (oCoreRst_n !== 1'b1) begin nFails++; $display("FAIL reset_corerst: got %b want 1", oCoreRst_n); end
    iReset_n = 1'b1;
    busRead(3'd1, d);
    nChecks++; if (d !== 32'h8) begin nFails++; $display("FAIL reset_status: got %h want 00000008", d); end
  endtask

  task automatic test_prefill_run();
    logic [31:0] d;
    logic [7:0] expPix [4];
    expPix[0] = 8'h11; expPix[1] = 8'h22; expPix[2] = 8'h33; expPix[3] = 8'h44;
    iPixelReady = 1'b1;
    for (int i = 0; i < 4; i++) busWrite(3'd0, {24'd0, expPix[i]});
    busWrite(3'd2, 32'h1);
    for (int i = 0; i < 4; i++) begin
      nChecks++;
      if (oPixelValid !== 1'b1 || oPixel !== expPix[i]) begin
        nFails++; $display("FAIL run_pixel%0d: got valid=%b pix=%h want valid=1 pix=%h", i, oPixelValid, oPixel, expPix[i]);
      end
      @(negedge iClk);
    end
    nChecks++; if (oPixelValid !== 1'b0) begin nFails++; $display("FAIL run_valid_after: got %b want 0", oPixelValid); end
    busRead(3'd3, d);
    nChecks++; if (d !== 32'd4) begin nFails++; $display("FAIL run_pixcnt: got %0d want 4", d); end
    busRead(3'd1, d);
    nChecks++; if (d !== 32'h9) begin nFails++; $display("FAIL run_status_wait: got %h want 00000009", d); end
    iDecision = 4'd7; iFinish = 1'b1;
    @(negedge iClk);
    iFinish = 1'b0;
    busRead(3'd0, d);
    nChecks++; if (d !== 32'd7) begin nFails++; $display("FAIL run_decision: got %h want 7", d); end
    busRead(3'd1, d);
    nChecks++; if (d !== 32'hA) begin nFails++; $display("FAIL run_status_done: got %h want 0000000a", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) busWrite(3'd0, 32'h55 + i);
    busWrite(3'd2, 32'h5);
    nChecks++; if (oIrq !== 1'b0) begin nFails++; $display("FAIL irq_after_start: got %b want 0", oIrq); end
    repeat (4) @(negedge iClk);
    iDecision = 4'd3; iFinish = 1'b1;
    @(negedge iClk);
    iFinish = 1'b0;
    nChecks++; if (oIrq !== 1'b0) begin nFails++; $display("FAIL irq_same_cycle: got %b want 0", oIrq); end
    @(negedge iClk);
    nChecks++; if (oIrq !== 1'b1) begin nFails++; $display("FAIL irq_assert: got %b want 1", oIrq); end
    busWrite(3'd4, 32'h1);
    nChecks++; if (oIrq !== 1'b0) begin nFails++; $display("FAIL irq_ack: got %b want 0", oIrq); end
    busRead(3'd1, d);
    nChecks++; if (d !== 32'h8) begin nFails++; $display("FAIL irq_status: got %h want 00000008", d); end
    busRead(3'd0, d);
    nChecks++; if (d !== 32'd3) begin nFails++; $display("FAIL irq_decision: got %h want 3", d); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    logic       rdyPat [4];
    logic [7:0] expPix [5];
    rdyPat[0] = 1'b1; rdyPat[1] = 1'b0; rdyPat[2] = 1'b0; rdyPat[3] = 1'b1;
    expPix[0] = 8'hA1; expPix[1] = 8'hA2; expPix[2] = 8'hA2; expPix[3] = 8'hA2; expPix[4] = 8'hA3;
    iPixelReady = 1'b0;
    for (int i = 0; i < 4; i++) busWrite(3'd0, 32'hA1 + i);
    busWrite(3'd2, 32'h1);
    for (int i = 0; i < 5; i++) begin
      nChecks++;
      if (oPixelValid !== 1'b1 || oPixel !== expPix[i]) begin
        nFails++; $display("FAIL bp_pixel%0d: got valid=%b pix=%h want valid=1 pix=%h", i, oPixelValid, oPixel, expPix[i]);
      end
      if (i < 4) begin
        iPixelReady = rdyPat[i];
        @(negedge iClk);
      end
    end
    iPixelReady = 1'b0;
    busRead(3'd3, d);
    nChecks++; if (d !== 32'd2) begin nFails++; $display("FAIL bp_pixcnt_mid: got %0d want 2", d); end
    iPixelReady = 1'b1;
    nChecks++; if (oPixel !== 8'hA3) begin nFails++; $display("FAIL bp_pixel_resume: got %h want a3", oPixel); end
    repeat (2) @(negedge iClk);
    iPixelReady = 1'b0;
    busRead(3'd3, d);
    nChecks++; if (d !== 32'd4) begin nFails++; $display("FAIL bp_pixcnt_end: got %0d want 4", d); end
    busRead(3'd1, d);
    nChecks++; if (d !== 32'h9) begin nFails++; $display("FAIL bp_status: got %h want 00000009", d); end
  endtask

  task automatic test_clear();
    logic [31:0] d;
    busWrite(3'd2, 32'h1);
    busRead(3'd3, d);
    nChecks++; if (d !== 32'd4) begin nFails++; $display("FAIL clr_start_ignored_cnt: got %0d want 4", d); end
    for (int i = 0; i < 17; i++) busWrite(3'd0, 32'h90 + i);
    busRead(3'd1, d);
    nChecks++; if (d !== 32'h1015) begin nFails++; $display("FAIL clr_status_full: got %h want 00001015", d); end
    busWrite(3'd2, 32'h3);
    nChecks++; if (oCoreRst_n !== 1'b0) begin nFails++; $display("FAIL clr_corerst_low: got %b want 0", oCoreRst_n); end
    @(negedge iClk);
    nChecks++; if (oCoreRst_n !== 1'b1) begin nFails++; $display("FAIL clr_corerst_high: got %b want 1", oCoreRst_n); end
    busRead(3'd1, d);
    nChecks++; if (d !== 32'h8) begin nFails++; $display("FAIL clr_status: got %h want 00000008", d); end
    busRead(3'd0, d);
    nChecks++; if (d !== 32'd3) begin nFails++; $display("FAIL clr_decision: got %h want 3", d); end
    busRead(3'd3, d);
    nChecks++; if (d !== 32'd0) begin nFails++; $display("FAIL clr_pixcnt: got %0d want 0", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [7:0]  expPix;
    bit          seen;
    iPixelReady = 1'b0;
    for (int i = 0; i < 17; i++) busWrite(3'd0, 32'h60 + i);
    busRead(3'd1, d);
    nChecks++; if (d !== 32'h1014) begin nFails++; $display("FAIL ovf_status: got %h want 00001014", d); end
    busWrite(3'd2, 32'h1);
    nChecks++; if (oPixelValid !== 1'b1 || oPixel !== 8'h60) begin nFails++; $display("FAIL ovf_head: got valid=%b pix=%h want 1/60", oPixelValid, oPixel); end
    iPixelReady = 1'b1;
    iChipSelect_n = 1'b0; iWrite_n = 1'b0; iAddress = 3'd0; iData = 32'h7E;
    @(negedge iClk);
    iChipSelect_n = 1'b1; iWrite_n = 1'b1; iPixelReady = 1'b0;
    nChecks++; if (oPixel !== 8'h61) begin nFails++; $display("FAIL ovf_pop_head: got %h want 61", oPixel); end
    busRead(3'd1, d);
    nChecks++; if (d !== 32'h1015) begin nFails++; $display("FAIL ovf_push_pop_level: got %h want 00001015", d); end
    iPixelReady = 1'b1;
    for (int idx = 1; idx < 17; idx++) begin
      if (idx % 4 == 0) begin
        iFinish = 1'b1;
        @(negedge iClk);
        iFinish = 1'b0;
        busWrite(3'd2, 32'h1);
      end
      seen = 1'b0;
      for (int w = 0; w < 20 && !seen; w++) begin
        if (oPixelValid) seen = 1'b1;
        else @(negedge iClk);
      end
      expPix = (idx < 16) ? 8'(8'h60 + idx) : 8'h7E;
      nChecks++;
      if (!seen || oPixel !== expPix) begin
        nFails++; $display("FAIL ovf_stream%0d: got valid=%b pix=%h want pix=%h", idx, seen, oPixel, expPix);
      end
      @(negedge iClk);
    end
    iPixelReady = 1'b0;
    nChecks++; if (oPixelValid !== 1'b0) begin nFails++; $display("FAIL ovf_drained_valid: got %b want 0", oPixelValid); end
    busRead(3'd1, d);
    nChecks++; if (d !== 32'hD) begin nFails++; $display("FAIL ovf_drained_status: got %h want 0000000d", d); end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] d;
    iPixelReady = 1'b0;
    busWrite(3'd0, 32'h31);
    busWrite(3'd0, 32'h32);
    nChecks++; if (oPixelValid !== 1'b1 || oPixel !== 8'h31) begin nFails++; $display("FAIL mid_valid: got valid=%b pix=%h want 1/31", oPixelValid, oPixel); end
    busRead(3'd1, d);
    nChecks++; if (d !== 32'h205) begin nFails++; $display("FAIL mid_status: got %h want 00000205", d); end
    #2 iReset_n = 1'b0;
    #1;
    nChecks++; if (oData !== 32'h0) begin nFails++; $display("FAIL mid_rst_odata: got %h want 0", oData); end
    nChecks++; if (oPixelValid !== 1'b0) begin nFails++; $display("FAIL mid_rst_valid: got %b want 0", oPixelValid); end
    nChecks++; if (oIrq !== 1'b0 || oCoreRst_n !== 1'b1) begin nFails++; $display("FAIL mid_rst_irq_corerst: got %b/%b want 0/1", oIrq, oCoreRst_n); end
    @(negedge iClk);
    iReset_n = 1'b1;
    busRead(3'd1, d);
    nChecks++; if (d !== 32'h8) begin nFails++; $display("FAIL mid_rst_status: got %h want 00000008", d); end
    busRead(3'd0, d);
    nChecks++; if (d !== 32'h0) begin nFails++; $display("FAIL mid_rst_decision: got %h want 0", d); end
  endtask

  initial begin
    iReset_n = 1'b0;
    iChipSelect_n = 1'b1; iWrite_n = 1'b1; iRead_n = 1'b1;
    iAddress = 3'd0; iData = 32'd0;
    iPixelReady = 1'b0; iDecision = '0; iFinish = 1'b0;
    test_reset();
    test_prefill_run();
    test_irq();
    test_backpressure();
    test_clear();
    test_overflow();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
